hazard_control_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core; successor to the single-cycle-decision load-use detector. Detects load-use hazards, holds the front end for a configurable number of cycles (multi-cycle data memory), squashes wrong-path instructions on taken branches/jumps, and freezes the whole pipeline while data memory reports busy. Sits beside the IF/ID and ID/EX registers and drives their write and flush enables plus the PC write enable; also keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_sat_counter.sv | 30 +++
 rtl/hazard_control_unit.sv | 109 ++++++++++
 tb/tb_hazard_control_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned RegAddrWDefault = 5;
  localparam int unsigned RemW            = 3;

  typedef enum logic [0:0] {
    StIdle,
    StLoadStall
  } hazard_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pipe_freeze;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CtrlNormal = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hazard_ctrl_t CtrlFreeze = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam hazard_ctrl_t CtrlFlush  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam hazard_ctrl_t CtrlStall  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous active-high clear.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-flush / memory-busy hazard controller for the 5-stage pipeline,
// with saturating stall and flush counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = RegAddrWDefault,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_rs1_used,
  input  logic                  if_id_rs2_used,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // The first bubble is issued from StIdle, so the FSM only covers the remainder.
  localparam logic [RemW-1:0] StallRem = RemW'(LOAD_STALL_CYCLES - 1);

  hazard_state_e   state_q, state_d;
  logic [RemW-1:0] rem_q, rem_d;
  hazard_ctrl_t    ctrl;
  logic            load_use;
  logic            stall_inc;
  logic            flush_inc;

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((if_id_rs1_used && (id_ex_rd == if_id_rs1)) ||
                     (if_id_rs2_used && (id_ex_rd == if_id_rs2)));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ctrl    = CtrlNormal;
    if (reset) begin
      ctrl = CtrlNormal;
    end else if (mem_busy) begin
      ctrl = CtrlFreeze;
    end else if (ex_branch_taken) begin
      // The dependent instruction is on the wrong path, so any pending stall is void.
      ctrl    = CtrlFlush;
      state_d = StIdle;
      rem_d   = '0;
    end else if (state_q == StLoadStall) begin
      ctrl  = CtrlStall;
      rem_d = rem_q - RemW'(1);
      if (rem_q <= RemW'(1)) begin
        state_d = StIdle;
        rem_d   = '0;
      end
    end else if (load_use) begin
      ctrl = CtrlStall;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = StLoadStall;
        rem_d   = StallRem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign pipe_freeze  = ctrl.pipe_freeze;

  assign stall_inc = !ctrl.pc_write;
  assign flush_inc = !reset && !mem_busy && ex_branch_taken;

  hazard_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  hazard_sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: three instances (1 and 3 stall cycles, 4-bit counters).
module tb_hazard_control_unit;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       busy;
  } stim_t;

  typedef struct {
    int         w;
    logic [4:0] e;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read;
  logic [4:0] rd, rs1, rs2;
  logic       rs1_used, rs2_used, br_taken, busy;

  logic        pcw1, ifw1, bub1, fl1, frz1;
  logic        pcw3, ifw3, bub3, fl3, frz3;
  logic        pcw4, ifw4, bub4, fl4, frz4;
  logic [15:0] sc1, fc1, sc3, fc3;
  logic [3:0]  sc4, fc4;

  int  total = 0;
  int  bad   = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
    .ex_branch_taken(br_taken), .mem_busy(busy), .pc_write(pcw1), .if_id_write(ifw1),
    .id_ex_bubble(bub1), .if_id_flush(fl1), .pipe_freeze(frz1), .stall_cnt(sc1),
    .flush_cnt(fc1)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
    .ex_branch_taken(br_taken), .mem_busy(busy), .pc_write(pcw3), .if_id_write(ifw3),
    .id_ex_bubble(bub3), .if_id_flush(fl3), .pipe_freeze(frz3), .stall_cnt(sc3),
    .flush_cnt(fc3)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
    .ex_branch_taken(br_taken), .mem_busy(busy), .pc_write(pcw4), .if_id_write(ifw4),
    .id_ex_bubble(bub4), .if_id_flush(fl4), .pipe_freeze(frz4), .stall_cnt(sc4),
    .flush_cnt(fc4)
  );

  // Control vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze}.
  function automatic logic [4:0] obs(input int w);
    case (w)
      1:       return {pcw1, ifw1, bub1, fl1, frz1};
      3:       return {pcw3, ifw3, bub3, fl3, frz3};
      default: return {pcw4, ifw4, bub4, fl4, frz4};
    endcase
  endfunction

  function automatic stim_t mk(input bit r, input bit m, input int unsigned d,
                               input int unsigned s1, input int unsigned s2, input bit a,
                               input bit b, input bit t, input bit y);
    stim_t s;
    s.rst = r; s.mr = m; s.rd = 5'(d); s.rs1 = 5'(s1); s.rs2 = 5'(s2);
    s.u1 = a; s.u2 = b; s.br = t; s.busy = y;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; mem_read = s.mr; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
    rs1_used = s.u1; rs2_used = s.u2; br_taken = s.br; busy = s.busy;
  endtask

  task automatic do_reset();
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    sq.push_back(mk(1, 1, 5, 5, 5, 1, 1, 1, 1)); eq.push_back(5'b11000);
    sq.push_back(mk(1, 1, 5, 5, 5, 1, 1, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{1, eq[i]}); sb.push_back('{3, eq[i]}); sb.push_back('{4, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL reset_outputs cyc%0d dut%0d got %b want %b", i, ent.w, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if ({sc1, fc1, sc3, fc3} !== 64'd0 || {sc4, fc4} !== 8'd0) begin
      bad++;
      $display("FAIL reset_counters got %h %h %h %h %h %h want all zero",
               sc1, fc1, sc3, fc3, sc4, fc4);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_load_use_single();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 5, 5, 0, 1, 0, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{1, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL load_use_single cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc1 !== 16'd1) begin
      bad++; $display("FAIL load_use_single stall_cnt got %0d want 1", sc1);
    end
  endtask

  task automatic test_no_match();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 1, 5, 3, 5, 1, 0, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 0, 5, 5, 5, 1, 1, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 1, 6, 6, 2, 0, 1, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 1, 9, 3, 9, 1, 1, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 9, 3, 9, 1, 1, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{1, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL no_match cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc1 !== 16'd1 || fc1 !== 16'd0) begin
      bad++; $display("FAIL no_match counters got stall=%0d flush=%0d want 1 0", sc1, fc1);
    end
  endtask

  task automatic test_multi_stall();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 1, 7, 2, 7, 0, 1, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 2, 7, 1, 1, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 2, 7, 1, 1, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 2, 7, 1, 1, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 0, 0, 2, 7, 1, 1, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{3, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL multi_stall cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc3 !== 16'd3) begin
      bad++; $display("FAIL multi_stall stall_cnt got %0d want 3", sc3);
    end
  endtask

  task automatic test_busy_during_stall();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 7, 0, 1, 0, 0, 1)); eq.push_back(5'b00001);
    sq.push_back(mk(0, 0, 0, 7, 0, 1, 0, 0, 1)); eq.push_back(5'b00001);
    sq.push_back(mk(0, 0, 0, 7, 0, 1, 0, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 7, 0, 1, 0, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(0, 0, 0, 7, 0, 1, 0, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{3, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL busy_during_stall cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc3 !== 16'd5) begin
      bad++; $display("FAIL busy_during_stall stall_cnt got %0d want 5", sc3);
    end
  endtask

  task automatic test_branch_flush();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 0)); eq.push_back(5'b11110);
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 1)); eq.push_back(5'b00001);
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{1, eq[i]}); sb.push_back('{3, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL branch_flush cyc%0d dut%0d got %b want %b", i, ent.w, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (fc1 !== 16'd1 || fc3 !== 16'd1 || sc3 !== 16'd1) begin
      bad++;
      $display("FAIL branch_flush counters got fc1=%0d fc3=%0d sc3=%0d want 1 1 1", fc1, fc3, sc3);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t      sq[$];
    logic [4:0] eq[$];
    sb_t        ent;
    do_reset();
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)); eq.push_back(5'b11110);
    sq.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0, 0)); eq.push_back(5'b00100);
    sq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(5'b11000);
    sq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); eq.push_back(5'b11000);
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]);
      sb.push_back('{3, eq[i]});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL reset_mid_stall cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc3 !== 16'd0 || fc3 !== 16'd0) begin
      bad++; $display("FAIL reset_mid_stall counters got %0d %0d want 0 0", sc3, fc3);
    end
  endtask

  task automatic test_saturation();
    sb_t ent;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      sb.push_back('{4, 5'b00001});
      @(negedge clk);
      while (sb.size() != 0) begin
        ent = sb.pop_front(); total++;
        if (obs(ent.w) !== ent.e) begin
          bad++;
          $display("FAIL saturation cyc%0d got %b want %b", i, obs(ent.w), ent.e);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (sc4 !== 4'd15) begin
      bad++; $display("FAIL saturation stall_cnt4 got %0d want 15", sc4);
    end
    total++;
    if (sc1 !== 16'd20) begin
      bad++; $display("FAIL saturation stall_cnt16 got %0d want 20", sc1);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use_single();
    test_no_match();
    test_multi_stall();
    test_busy_during_stall();
    test_branch_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
